// File: rtl/led_bank_sequencer.sv
// Autonomous instruction master for an eight-LED bank: emits one pattern
// instruction every PERIOD clocks while running, plus clear instructions.
//
// Handshake: inst_en is a single-cycle valid strobe with no ready; the LED bank
// must accept inst in the cycle inst_en=1. inst is 12'h000 whenever inst_en=0.
module led_bank_sequencer #(
    parameter int unsigned PERIOD = 1000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  mode,
    output logic [11:0] inst,
    output logic        inst_en,
    output logic        busy,
    output logic [2:0]  debug_state
);

    typedef enum logic [2:0] {
        ST_RESET = 3'd0,
        ST_CLEAR = 3'd1,
        ST_IDLE  = 3'd2,
        ST_RUN   = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

    localparam logic [31:0] TICK_AT   = PERIOD - 1;
    localparam logic [11:0] CLEAR_INST = 12'h100;

    state_t      state, state_d;
    logic [31:0] presc, presc_d;
    logic [3:0]  step, step_d;
    logic [7:0]  val, val_d;
    logic [1:0]  mode_q, mode_d;
    logic [11:0] inst_d;
    logic        inst_en_d;
    logic        busy_d;

    function automatic logic [11:0] pattern_inst(input logic [1:0] m,
                                                 input logic [3:0] s,
                                                 input logic [7:0] v);
        case (m)
            2'd0:    pattern_inst = {4'h1, 8'h01 << s[2:0]};
            2'd1:    pattern_inst = {4'h1, v};
            2'd2:    pattern_inst = {4'h2 + {1'b0, s[2:0]}, {7'd0, ~s[3]}};
            default: pattern_inst = {4'h1, s[0] ? 8'h00 : 8'hFF};
        endcase
    endfunction

    function automatic logic [3:0] next_step(input logic [1:0] m, input logic [3:0] s);
        case (m)
            2'd0:    next_step = {1'b0, s[2:0] + 3'd1};
            2'd1:    next_step = s;
            2'd2:    next_step = s + 4'd1;
            default: next_step = {3'd0, ~s[0]};
        endcase
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= ST_RESET;
            presc   <= '0;
            step    <= '0;
            val     <= '0;
            mode_q  <= '0;
            inst    <= '0;
            inst_en <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= state_d;
            presc   <= presc_d;
            step    <= step_d;
            val     <= val_d;
            mode_q  <= mode_d;
            inst    <= inst_d;
            inst_en <= inst_en_d;
            busy    <= busy_d;
        end
    end

    always_comb begin
        state_d   = state;
        presc_d   = presc;
        step_d    = step;
        val_d     = val;
        mode_d    = mode_q;
        inst_d    = '0;
        inst_en_d = 1'b0;
        busy_d    = 1'b0;
        case (state)
            ST_RESET: state_d = ST_CLEAR;
            ST_CLEAR: begin
                inst_d    = CLEAR_INST;
                inst_en_d = 1'b1;
                state_d   = ST_IDLE;
            end
            ST_IDLE: begin
                // stop has priority over start when both are high
                if (start && !stop) begin
                    mode_d    = mode;
                    presc_d   = '0;
                    inst_d    = pattern_inst(mode, 4'd0, 8'd0);
                    inst_en_d = 1'b1;
                    step_d    = next_step(mode, 4'd0);
                    val_d     = (mode == 2'd1) ? 8'd1 : 8'd0;
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                busy_d = 1'b1;
                if (stop) begin
                    inst_d    = CLEAR_INST;
                    inst_en_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end else if (presc == TICK_AT) begin
                    inst_d    = pattern_inst(mode_q, step, val);
                    inst_en_d = 1'b1;
                    step_d    = next_step(mode_q, step);
                    val_d     = (mode_q == 2'd1) ? val + 8'd1 : val;
                    presc_d   = '0;
                end else begin
                    presc_d = presc + 32'd1;
                end
            end
            ST_ERROR: state_d = ST_ERROR;
            default:  state_d = ST_ERROR;
        endcase
    end

    assign debug_state = state;

endmodule
